block_merger: RTL
=================

# block_merger

Decoder-side inverse of the 8x8 block splitter: accepts pixels of one channel in block order and re-emits them in raster order. Sits after the 2D IDCT on each of the Y, Cb and Cr paths of the JPEG decoder, ahead of upsampling and YCbCr-to-RGB conversion. Buffers one 8-row strip of the image, then drains it with a valid/ready handshake. Input stalls while a strip drains.

## Interface
- IMG_W, 64, image width in pixels; multiple of 8, at least 8
- IMG_H, 64, image height in pixels; multiple of 8, at least 8
- DATA_W, 8, pixel width in bits
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins an image; honoured only in IDLE
- pixel_in  in  DATA_W  block-order pixel
- valid_in  in  1  pixel_in valid
- in_ready  out  1  block_merger can accept; transfer = valid_in & in_ready
- pixel_out  out  DATA_W  raster-order pixel
- valid_out  out  1  pixel_out valid
- out_ready  in  1  downstream accepts; transfer = valid_out & out_ready
- strip_done  out  1  one-cycle pulse after the last pixel of a strip is transferred out
- img_done  out  1  one-cycle pulse after the last pixel of the image is transferred out

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: start goes to FILL and clears all counters.
- FILL:
  - in_ready=1.
  - Input order within a strip: blocks left to right; within a block, row-major (r 0..7, c 0..7).
  - Write address = r*IMG_W + blk*8 + c. Counters c, r and blk (0..IMG_W/8-1) wrap in that nesting.
  - Go to DRAIN on the transfer of pixel 8*IMG_W-1.
- DRAIN:
  - valid_out=1.
  - pixel_out = buffer[rd_addr], read combinationally. rd_addr runs 0..8*IMG_W-1.
  - rd_addr increments on each output transfer.
  - On the last transfer:
    - strip_done pulses the next cycle.
    - strip count increments.
    - Go to FILL if strips < IMG_H/8, otherwise go to DONE.
- DONE: img_done=1 for exactly one cycle, then go to IDLE.
- in_ready=0 outside FILL. valid_out=0 outside DRAIN.
- start outside IDLE is ignored.
- valid_in outside FILL is ignored, and the data is not stored.
- out_ready=0 in DRAIN: pixel_out and rd_addr hold.
- Reset values: in_ready=0, valid_out=0, pixel_out=0 when not in DRAIN, strip_done=0, img_done=0, state IDLE, all counters 0.
- Buffer contents are not reset.
- Reset mid-operation drops the partial strip or image. The next image needs a fresh start.
- Counter widths are sized by $clog2 of their ranges. There is no arithmetic on pixel data.

## Timing
- FILL of a full strip with valid_in held high takes 8*IMG_W cycles.
- The first valid_out rises the cycle after the last input transfer.
- DRAIN with out_ready held high takes 8*IMG_W cycles.
- strip_done is asserted in the cycle the state enters FILL or DONE.
- For the last strip, strip_done and img_done are asserted in the same cycle.
- Best-case image time is IMG_H/8 * 16*IMG_W cycles plus 2.
- strip_done and img_done are registered outputs.
- in_ready and valid_out are decoded from the registered state. They are never combinational on valid_in or out_ready.

## Structure
- The shared package jpeg_pkg holds:
  - BLK_SIZE=8
  - the state encoding typedef for merger/splitter FSMs
  - a helper for buffer address width: $clog2(8*IMG_W)
- Sub-module strip_buffer:
  - depth 8*IMG_W, width DATA_W
  - one synchronous write port, one asynchronous read port
  - no reset
- Top level holds the FSM and the c/r/blk/rd_addr/strip counters.

## Test plan
- IMG_W=16, IMG_H=16. start, then 256 block-order pixels with value = (row*16+col) mod 256, out_ready high.
  - Required: pixel_out sequence is 0,1,2,...,255 in raster order.
  - Required: strip_done pulses twice, the second time together with img_done.
  - Required: in_ready is low during each drain.
- Same image, out_ready toggling with a 1-on/2-off pattern.
  - Required: pixel_out holds while out_ready is low.
  - Required: no pixel is lost or duplicated.
  - Required: the drain of strip 0 takes 384 cycles.
- Same image, valid_in with random gaps.
  - Required: output sequence is unchanged.
  - Required: pixels presented while in_ready=0 are not stored.
- start pulses during FILL and DRAIN.
  - Required: no effect.
  - Required: a start in IDLE after img_done begins a new image, and its output matches.
- rst_n low for 1 cycle midway through the drain of strip 0.
  - Required: next cycle valid_out=0, in_ready=0, state IDLE.
  - Required: a new start plus a full image produces a correct raster output.
- IMG_W=8, IMG_H=8 (single block).
  - Required: 64 inputs produce 64 identical-order outputs.
  - Required: strip_done and img_done assert together, exactly once.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: definitions shared by the JPEG block splitter / merger datapath.
//   BLK_SIZE     : edge length of a JPEG block (8)
//   fsm_state_t  : state encoding used by the merger and splitter FSMs
//   buf_addr_w() : address width of an 8-row strip buffer for a given width
package jpeg_pkg;

    localparam int BLK_SIZE = 8;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_FILL  = 2'd1;
    localparam fsm_state_t ST_DRAIN = 2'd2;
    localparam fsm_state_t ST_DONE  = 2'd3;

    // Address width of a buffer that holds BLK_SIZE full image rows.
    function automatic int buf_addr_w(input int img_w);
        return $clog2(BLK_SIZE * img_w);
    endfunction

endpackage

// File: rtl/strip_buffer.sv
// strip_buffer: storage for one 8-row strip of one colour channel.
//   i_clk    : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (asynchronous read)
//   o_rdata  : read data
// Contents are deliberately not reset; every location is written during FILL
// before it is ever read during DRAIN.
module strip_buffer #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 8,
    parameter int AW     = 9
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/block_merger.sv
// block_merger: accepts one channel's pixels in 8x8 block order, buffers an
// 8-row strip and re-emits it in raster order.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_start            : begins an image (honoured only in IDLE)
//   i_pixel_in/valid_in: block-order input, accepted when o_in_ready
//   o_in_ready         : high in FILL only
//   o_pixel_out        : raster-order output, valid when o_valid_out
//   o_valid_out        : high in DRAIN only
//   i_out_ready        : downstream accept
//   o_strip_done       : one-cycle pulse after a strip has fully drained
//   o_img_done         : one-cycle pulse after the whole image has drained
module block_merger
    import jpeg_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_pixel_in,
    input  logic              i_valid_in,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_pixel_out,
    output logic              o_valid_out,
    input  logic              i_out_ready,
    output logic              o_strip_done,
    output logic              o_img_done
);

    localparam int DEPTH   = BLK_SIZE * IMG_W;
    localparam int AW      = buf_addr_w(IMG_W);
    localparam int NBLK    = IMG_W / BLK_SIZE;
    localparam int BLK_W   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int NSTRIP  = IMG_H / BLK_SIZE;
    localparam int STRIP_W = $clog2(NSTRIP + 1);
    localparam int PIX_W   = $clog2(BLK_SIZE);

    fsm_state_t         r_state;
    logic [PIX_W-1:0]   r_col;
    logic [PIX_W-1:0]   r_row;
    logic [BLK_W-1:0]   r_blk;
    logic [AW-1:0]      r_rd_addr;
    logic [STRIP_W-1:0] r_strip;
    logic               r_strip_done;
    logic               r_img_done;

    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_last_in;
    logic               w_last_out;

    // Block-order position (row r, block blk, column c) maps to raster address.
    assign w_wr_addr = (AW'(r_row) * AW'(IMG_W)) + (AW'(r_blk) * AW'(BLK_SIZE)) + AW'(r_col);
    assign w_wr_en   = (r_state == ST_FILL) && i_valid_in;

    assign w_last_in  = (r_col == {PIX_W{1'b1}}) && (r_row == {PIX_W{1'b1}}) &&
                        (r_blk == BLK_W'(NBLK - 1));
    assign w_last_out = (r_rd_addr == AW'(DEPTH - 1));

    strip_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_strip_buffer (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (i_pixel_in),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Handshake flags come straight from the registered state, never from inputs.
    assign o_in_ready   = (r_state == ST_FILL);
    assign o_valid_out  = (r_state == ST_DRAIN);
    assign o_pixel_out  = (r_state == ST_DRAIN) ? w_rd_data : {DATA_W{1'b0}};
    assign o_strip_done = r_strip_done;
    assign o_img_done   = r_img_done;

    // FSM, fill/drain counters and done pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= {PIX_W{1'b0}};
            r_row        <= {PIX_W{1'b0}};
            r_blk        <= {BLK_W{1'b0}};
            r_rd_addr    <= {AW{1'b0}};
            r_strip      <= {STRIP_W{1'b0}};
            r_strip_done <= 1'b0;
            r_img_done   <= 1'b0;
        end else begin
            r_strip_done <= 1'b0;
            r_img_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_col     <= {PIX_W{1'b0}};
                        r_row     <= {PIX_W{1'b0}};
                        r_blk     <= {BLK_W{1'b0}};
                        r_rd_addr <= {AW{1'b0}};
                        r_strip   <= {STRIP_W{1'b0}};
                        r_state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (i_valid_in) begin
                        // c wraps into r, r wraps into blk; all three return
                        // to zero together on the last pixel of the strip.
                        r_col <= r_col + {{(PIX_W-1){1'b0}}, 1'b1};
                        if (r_col == {PIX_W{1'b1}}) begin
                            r_row <= r_row + {{(PIX_W-1){1'b0}}, 1'b1};
                            if (r_row == {PIX_W{1'b1}}) begin
                                if (r_blk == BLK_W'(NBLK - 1)) begin
                                    r_blk <= {BLK_W{1'b0}};
                                end else begin
                                    r_blk <= r_blk + BLK_W'(1);
                                end
                            end
                        end
                        if (w_last_in) begin
                            r_rd_addr <= {AW{1'b0}};
                            r_state   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_out_ready) begin
                        if (w_last_out) begin
                            r_rd_addr    <= {AW{1'b0}};
                            r_strip      <= r_strip + STRIP_W'(1);
                            r_strip_done <= 1'b1;
                            if (r_strip == STRIP_W'(NSTRIP - 1)) begin
                                r_img_done <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_state    <= ST_FILL;
                            end
                        end else begin
                            r_rd_addr <= r_rd_addr + AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
